// File: rtl/raster_scan_ctrl.sv
// Raster scan coordinate generator: walks x/y over an IMG_W x IMG_H frame with
// valid/ready handshaking, optional inter-line blanking and a one-cycle done pulse.
module raster_scan_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int H_BLANK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [$clog2(IMG_W)-1:0] x,
    output logic [$clog2(IMG_H)-1:0] y,
    output logic                     sof,
    output logic                     eol,
    output logic                     eof,
    output logic                     busy,
    output logic                     done
);

    localparam int XW       = $clog2(IMG_W);
    localparam int YW       = $clog2(IMG_H);
    // A zero-length gap never enters BLANK, but the counter still needs one bit.
    localparam int GW       = (H_BLANK > 0) ? $clog2(H_BLANK + 1) : 1;
    localparam int GAP_LAST = (H_BLANK > 0) ? H_BLANK - 1 : 0;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_LAST);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        BLANK,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [XW-1:0] x_cnt;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_cnt;
    logic [YW-1:0] y_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x_cnt   <= '0;
            y_cnt   <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            x_cnt   <= x_next;
            y_cnt   <= y_next;
            gap_cnt <= gap_next;
        end
    end

    always_comb begin
        state_next = state;
        x_next     = x_cnt;
        y_next     = y_cnt;
        gap_next   = gap_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (x_cnt == X_LAST) begin
                        x_next = '0;
                        if (y_cnt == Y_LAST) begin
                            y_next     = '0;
                            state_next = DONE;
                        end else begin
                            y_next     = y_cnt + 1'b1;
                            state_next = (H_BLANK > 0) ? BLANK : SCAN;
                        end
                    end else begin
                        x_next = x_cnt + 1'b1;
                    end
                end
            end
            BLANK: begin
                if (gap_cnt == G_LAST) begin
                    gap_next   = '0;
                    state_next = SCAN;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything above, including a start seen in IDLE.
        if (abort) begin
            state_next = IDLE;
            x_next     = '0;
            y_next     = '0;
            gap_next   = '0;
        end
    end

    assign out_valid = (state == SCAN);
    assign x         = x_cnt;
    assign y         = y_cnt;
    assign sof       = out_valid && (x_cnt == '0) && (y_cnt == '0);
    assign eol       = out_valid && (x_cnt == X_LAST);
    assign eof       = out_valid && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
